eth_rx_frame_fifo: RTL and testbench

ETH_RX_FRAME_FIFO -- requirements
Module: eth_rx_frame_fifo

---
 rtl/eth_pkg.sv | 22 ++
 rtl/eth_rx_frame_fifo_if.sv | 13 +
 rtl/eth_frame_ram.sv | 28 ++
 rtl/eth_rx_frame_fifo.sv | 136 +++++++++++++
 tb/tb_eth_rx_frame_fifo.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared types and defaults for the Ethernet receive store-and-forward FIFO.
package eth_pkg;

    // Default log2 of the byte store depth (2048 bytes: one 1518-byte frame plus margin)
    localparam int ADDR_W_DEF = 11;
    // Default width of the status counters
    localparam int CNT_W_DEF  = 16;

    // Input side frame state
    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } rx_state_t;

    // One stored byte: the last flag sits in bit 8, the data byte in bits 7:0
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/eth_rx_frame_fifo_if.sv
// Byte stream with frame delimiting and error flag; ready flows back to the source.
interface eth_rx_frame_fifo_if;

    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       user;
    logic       ready;

    modport master (output data, valid, last, user, input ready);
    modport slave  (input data, valid, last, user, output ready);

endinterface

// File: rtl/eth_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port, no reset.
module eth_frame_ram
    import eth_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  entry_t            wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output entry_t            rd_q
);

    entry_t mem [2**ADDR_W];

    // Store one byte per accepted beat
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read; the output holds its value while no read is issued
    always_ff @(posedge clk) begin
        if (rd_en) rd_q <= mem[rd_addr];
    end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive FIFO: frames become visible only once their last
// byte is committed; errored and overflowing frames are dropped and counted.
module eth_rx_frame_fifo
    import eth_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    eth_rx_frame_fifo_if.slave  mac_rx,
    eth_rx_frame_fifo_if.master rx,
    output logic [CNT_W-1:0]    drop_err_cnt,
    output logic [CNT_W-1:0]    drop_ovf_cnt,
    output logic [CNT_W-1:0]    frame_cnt
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    rx_state_t        state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_commit;
    logic [PTR_W-1:0] rd_ptr;      // advances only when the consumer takes a byte
    logic [PTR_W-1:0] fetch_ptr;   // next RAM address to prefetch
    logic             full;
    logic             wr_en;
    logic             avail;
    logic             out_free;
    logic             move;
    logic             issue;
    logic             vld_p1;
    entry_t           wr_entry;
    entry_t           entry_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Space is freed only by consumer transfers, so prefetched bytes still count as occupied
    assign full     = (wr_ptr - rd_ptr) == DEPTH;
    assign wr_en    = (state == ST_PASS) && mac_rx.valid && !full;
    assign wr_entry = '{last: mac_rx.last, data: mac_rx.data};

    // The MAC cannot be stalled
    assign mac_rx.ready = 1'b1;
    // Only good frames are ever forwarded
    assign rx.user = 1'b0;

    // Input FSM: resync to a frame boundary, then write, commit or roll back frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_SYNC;
            wr_ptr       <= '0;
            wr_commit    <= '0;
            drop_err_cnt <= '0;
            drop_ovf_cnt <= '0;
            frame_cnt    <= '0;
        end else if (mac_rx.valid) begin
            case (state)
                ST_SYNC: begin
                    if (mac_rx.last) state <= ST_PASS;
                end
                ST_PASS: begin
                    if (full) begin
                        wr_ptr <= wr_commit;
                        if (mac_rx.last) drop_ovf_cnt <= sat_inc(drop_ovf_cnt);
                        else             state        <= ST_DROP;
                    end else if (mac_rx.last && mac_rx.user) begin
                        wr_ptr       <= wr_commit;
                        drop_err_cnt <= sat_inc(drop_err_cnt);
                    end else if (mac_rx.last) begin
                        wr_ptr    <= wr_ptr + 1'b1;
                        wr_commit <= wr_ptr + 1'b1;
                        frame_cnt <= frame_cnt + 1'b1;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                end
                ST_DROP: begin
                    if (mac_rx.last) begin
                        drop_ovf_cnt <= sat_inc(drop_ovf_cnt);
                        state        <= ST_PASS;
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

    eth_frame_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_entry),
        .rd_en   (issue),
        .rd_addr (fetch_ptr[ADDR_W-1:0]),
        .rd_q    (entry_p1)
    );

    // Read pipeline: RAM output stage feeds the output register when it is free
    assign avail    = fetch_ptr != wr_commit;
    assign out_free = !rx.valid || rx.ready;
    assign move     = vld_p1 && out_free;
    assign issue    = avail && (!vld_p1 || move);

    // Read pointers and RAM output stage valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_ptr <= '0;
            rd_ptr    <= '0;
            vld_p1    <= 1'b0;
        end else begin
            if (issue)                fetch_ptr <= fetch_ptr + 1'b1;
            if (rx.valid && rx.ready) rd_ptr    <= rd_ptr + 1'b1;
            if (issue)                vld_p1    <= 1'b1;
            else if (move)            vld_p1    <= 1'b0;
        end
    end

    // Output register: load from the RAM stage, hold while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx.valid <= 1'b0;
            rx.data  <= '0;
            rx.last  <= 1'b0;
        end else if (move) begin
            rx.valid <= 1'b1;
            rx.data  <= entry_p1.data;
            rx.last  <= entry_p1.last;
        end else if (rx.ready) begin
            rx.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Directed bench for eth_rx_frame_fifo: a default-size instance and a 64-byte instance.
module tb_eth_rx_frame_fifo;
    import eth_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    eth_rx_frame_fifo_if mac0 ();
    eth_rx_frame_fifo_if rx0 ();
    eth_rx_frame_fifo_if mac1 ();
    eth_rx_frame_fifo_if rx1 ();

    logic [15:0] derr0, dovf0, fcnt0;
    logic [15:0] derr1, dovf1, fcnt1;

    eth_rx_frame_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .mac_rx       (mac0),
        .rx           (rx0),
        .drop_err_cnt (derr0),
        .drop_ovf_cnt (dovf0),
        .frame_cnt    (fcnt0)
    );

    eth_rx_frame_fifo #(.ADDR_W(6)) dut_small (
        .clk          (clk),
        .rst          (rst),
        .mac_rx       (mac1),
        .rx           (rx1),
        .drop_err_cnt (derr1),
        .drop_ovf_cnt (dovf1),
        .frame_cnt    (fcnt1)
    );

    always #5 clk = ~clk;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       hold0 = 1'b0;
    logic       hold1 = 1'b0;
    logic [8:0] held0 = '0;
    logic [8:0] held1 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Collect transferred bytes and check that stalled outputs stay stable
    always @(negedge clk) begin
        if (hold0 && rst) chk("hold0", {22'd0, rx0.valid, rx0.last, rx0.data}, {22'd0, 1'b1, held0});
        if (hold1 && rst) chk("hold1", {22'd0, rx1.valid, rx1.last, rx1.data}, {22'd0, 1'b1, held1});
        if (rst && rx0.valid && rx0.ready) q0.push_back({rx0.last, rx0.data});
        if (rst && rx1.valid && rx1.ready) q1.push_back({rx1.last, rx1.data});
        hold0 = rst && rx0.valid && !rx0.ready;
        hold1 = rst && rx1.valid && !rx1.ready;
        held0 = {rx0.last, rx0.data};
        held1 = {rx1.last, rx1.data};
    end

    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l, input logic u);
        if (sel == 0) begin
            mac0.valid = v; mac0.data = d; mac0.last = l; mac0.user = u;
        end else begin
            mac1.valid = v; mac1.data = d; mac1.last = l; mac1.user = u;
        end
    endtask

    // Back-to-back beats start+0 .. start+len-1; returns #1 after the edge sampling the last beat
    task automatic send(input int sel, input int len, input int start, input logic user);
        for (int i = 0; i < len; i++) begin
            drive(sel, 1'b1, 8'(start + i), (i == len - 1), (i == len - 1) && user);
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_q(input int sel, input int n, input string tag);
        int k;
        k = 0;
        while (((sel == 0) ? q0.size() : q1.size()) < n && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(tag, 32'(((sel == 0) ? q0.size() : q1.size()) >= n), 32'd1);
    endtask

    task automatic check_frame(input int sel, input string tag, input int len, input int start);
        logic [9:0] got;
        logic [9:0] exp;
        for (int i = 0; i < len; i++) begin
            got = 10'h3FF;
            if (sel == 0 && q0.size() > 0) got = {1'b0, q0.pop_front()};
            if (sel != 0 && q1.size() > 0) got = {1'b0, q1.pop_front()};
            exp = {1'b0, (i == len - 1), 8'(start + i)};
            chk($sformatf("%s[%0d]", tag, i), {22'd0, got}, {22'd0, exp});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        rx0.ready = 1'b1;
        rx1.ready = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rx0.valid, 0);
        chk("rst_data", rx0.data, 0);
        chk("rst_last", rx0.last, 0);
        chk("rst_user", rx0.user, 0);
        chk("rst_drops", {derr0, dovf0}, 0);
        chk("rst_fcnt", fcnt0, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Tail of a partial frame, then a full 64-byte frame
        send(0, 5, 8'hA0, 1'b0);
        send(0, 64, 8'h00, 1'b0);
        chk("store_fwd_valid", rx0.valid, 0);
        chk("store_fwd_empty", q0.size(), 0);
        wait_q(0, 64, "f64_wait");
        check_frame(0, "f64", 64, 8'h00);
        chk("f64_fcnt", fcnt0, 1);

        // Latency of a 1-byte frame into an empty FIFO
        send(0, 1, 8'h5A, 1'b0);
        chk("lat_n0", rx0.valid, 0);
        @(posedge clk); #1;
        chk("lat_n1", rx0.valid, 0);
        @(posedge clk); #1;
        chk("lat_n2_valid", rx0.valid, 1);
        chk("lat_n2_data", rx0.data, 8'h5A);
        chk("lat_n2_last", rx0.last, 1);
        @(posedge clk); #1;
        chk("lat_n3", rx0.valid, 0);
        check_frame(0, "lat", 1, 8'h5A);

        // Back-to-back 60- and 1-byte frames under random backpressure
        fork
            begin
                send(0, 60, 8'h40, 1'b0);
                send(0, 1, 8'hC5, 1'b0);
            end
            begin
                for (int c = 0; c < 3000 && q0.size() < 61; c++) begin
                    rx0.ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        rx0.ready = 1'b1;
        wait_q(0, 61, "b2b_wait");
        check_frame(0, "f60", 60, 8'h40);
        check_frame(0, "f1", 1, 8'hC5);
        chk("b2b_fcnt", fcnt0, 4);

        // Errored frame is dropped, the following good frame passes
        send(0, 100, 8'h00, 1'b1);
        send(0, 20, 8'h20, 1'b0);
        wait_q(0, 20, "f20_wait");
        check_frame(0, "f20", 20, 8'h20);
        chk("err_cnt", derr0, 1);
        chk("err_fcnt", fcnt0, 5);
        repeat (10) @(posedge clk);
        #1;
        chk("err_no_extra", q0.size(), 0);

        // 64-byte store, consumer stalled: overflow drops and an exact fill
        send(1, 1, 8'hEE, 1'b0);
        send(1, 40, 8'h10, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("small_hold_valid", rx1.valid, 1);
        chk("small_hold_data", rx1.data, 8'h10);
        chk("small_f40_fcnt", fcnt1, 1);
        send(1, 30, 8'h80, 1'b0);
        chk("small_ovf1", dovf1, 1);
        chk("small_ovf1_fcnt", fcnt1, 1);
        send(1, 24, 8'hC0, 1'b0);
        chk("small_fill_fcnt", fcnt1, 2);
        chk("small_fill_ovf", dovf1, 1);
        send(1, 1, 8'hF0, 1'b0);
        chk("small_full_last_ovf", dovf1, 2);
        chk("small_full_last_fcnt", fcnt1, 2);
        rx1.ready = 1'b1;
        wait_q(1, 64, "small_wait");
        check_frame(1, "s40", 40, 8'h10);
        check_frame(1, "s24", 24, 8'hC0);
        repeat (10) @(posedge clk);
        #1;
        chk("small_no_extra", q1.size(), 0);

        // Reset in the middle of reading out a 200-byte frame
        send(0, 200, 8'h00, 1'b0);
        wait_q(0, 50, "big_wait");
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", rx0.valid, 0);
        chk("mid_rst_fcnt", fcnt0, 0);
        chk("mid_rst_drops", {derr0, dovf0}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        q0.delete();
        send(0, 3, 8'h77, 1'b0);
        send(0, 10, 8'hE0, 1'b0);
        wait_q(0, 10, "fresh_wait");
        check_frame(0, "fresh", 10, 8'hE0);
        chk("fresh_fcnt", fcnt0, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("fresh_no_extra", q0.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
